// File: rtl/time_entry_if.sv
// Keypad / countdown-chain bus for the time entry block.
// The master side drives keypad and control inputs; the slave side returns digits and load strobe.
interface time_entry_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start;
  logic       running;
  logic [3:0] min_digit;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       loadn;
  logic       busy;

  modport master (
    output key_valid, key_code, start, running,
    input  min_digit, sec_tens, sec_ones, loadn, busy
  );

  modport slave (
    input  key_valid, key_code, start, running,
    output min_digit, sec_tens, sec_ones, loadn, busy
  );
endinterface

// File: rtl/time_entry.sv
// Time entry: collects M:ST:SO digits from a keypad, normalizes seconds >= 60 into minutes
// (saturating at 9:59), then pulses loadn low for one cycle to load the countdown chain.
module time_entry (
  input  logic         clock,
  input  logic         clear,
  time_entry_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StNorm, StLoad} state_e;

  state_e     state_q, state_d;
  logic [3:0] min_q, min_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       loadn_q, loadn_d;
  logic       fresh_q, fresh_d;
  logic       key_ok;
  logic       start_ok;

  // Qualify keypad digits and start requests; start takes priority over a same-cycle key.
  always_comb begin
    key_ok   = bus.key_valid && (bus.key_code <= 4'd9) && !bus.running && !bus.start;
    start_ok = bus.start && !bus.running && ((min_q | tens_q | ones_q) != 4'd0);
  end

  // Next-state and datapath: digit shift in IDLE, minute normalization in NORM, strobe in LOAD.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    fresh_d = fresh_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StNorm;
        end else if (key_ok) begin
          if (fresh_q) begin
            // First key after a load starts a new entry from 0:00.
            min_d   = 4'd0;
            tens_d  = 4'd0;
            ones_d  = bus.key_code;
            fresh_d = 1'b0;
          end else begin
            min_d  = tens_q;
            tens_d = ones_q;
            ones_d = bus.key_code;
          end
        end
      end
      StNorm: begin
        if (tens_q >= 4'd6) begin
          if (min_q <= 4'd8) begin
            tens_d = tens_q - 4'd6;
            min_d  = min_q + 4'd1;
          end else begin
            min_d  = 4'd9;
            tens_d = 4'd5;
            ones_d = 4'd9;
          end
        end
        state_d = StLoad;
      end
      StLoad: begin
        fresh_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Registered strobe: low exactly while the state register holds LOAD.
    loadn_d = (state_d != StLoad);
  end

  // State and digit registers with synchronous clear overriding everything.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= StIdle;
      min_q   <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      loadn_q <= 1'b1;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      loadn_q <= loadn_d;
      fresh_q <= fresh_d;
    end
  end

  assign bus.min_digit = min_q;
  assign bus.sec_tens  = tens_q;
  assign bus.sec_ones  = ones_q;
  assign bus.loadn     = loadn_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_time_entry.sv
// Directed self-checking bench for time_entry.
module tb_time_entry;

  logic clock;
  logic clear;
  int   errors;
  int   checks;
  logic [11:0] digits;

  time_entry_if bus ();

  time_entry dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  assign digits = {bus.min_digit, bus.sec_tens, bus.sec_ones};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd5;
    bus.start     = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    bus.key_valid = 1'b0;
    bus.start     = 1'b0;
    checks++; if (digits !== 12'h000) begin errors++; $display("FAIL reset_digits got %h want 000", digits); end
    checks++; if (bus.loadn !== 1'b1) begin errors++; $display("FAIL reset_loadn got %b want 1", bus.loadn); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_normal_load();
    press(4'd1);
    press(4'd3);
    press(4'd0);
    checks++; if (digits !== 12'h130) begin errors++; $display("FAIL entry_130 got %h want 130", digits); end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL norm_busy got %b want 1", bus.busy); end
    checks++; if (bus.loadn !== 1'b1) begin errors++; $display("FAIL norm_loadn got %b want 1", bus.loadn); end
    tick();
    checks++; if (bus.loadn !== 1'b0) begin errors++; $display("FAIL load_loadn got %b want 0", bus.loadn); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b want 1", bus.busy); end
    checks++; if (digits !== 12'h130) begin errors++; $display("FAIL load_data got %h want 130", digits); end
    tick();
    checks++; if (bus.loadn !== 1'b1) begin errors++; $display("FAIL post_loadn got %b want 1", bus.loadn); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_busy got %b want 0", bus.busy); end
    checks++; if (digits !== 12'h130) begin errors++; $display("FAIL hold_data got %h want 130", digits); end
  endtask

  task automatic test_normalize();
    press(4'd9);
    press(4'd0);
    checks++; if (digits !== 12'h090) begin errors++; $display("FAIL entry_090 got %h want 090", digits); end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++; if (bus.loadn !== 1'b0) begin errors++; $display("FAIL norm_load_strobe got %b want 0", bus.loadn); end
    checks++; if (digits !== 12'h130) begin errors++; $display("FAIL norm_result got %h want 130", digits); end
    tick();
    press(4'd9);
    press(4'd9);
    press(4'd9);
    checks++; if (digits !== 12'h999) begin errors++; $display("FAIL entry_999 got %h want 999", digits); end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++; if (bus.loadn !== 1'b0) begin errors++; $display("FAIL sat_load_strobe got %b want 0", bus.loadn); end
    checks++; if (digits !== 12'h959) begin errors++; $display("FAIL saturate got %h want 959", digits); end
    tick();
  endtask

  task automatic test_overflow_fresh();
    do_clear();
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    checks++; if (digits !== 12'h234) begin errors++; $display("FAIL shift_overflow got %h want 234", digits); end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++; if (digits !== 12'h234) begin errors++; $display("FAIL load_234 got %h want 234", digits); end
    tick();
    press(4'd7);
    checks++; if (digits !== 12'h007) begin errors++; $display("FAIL fresh_key got %h want 007", digits); end
    press(4'd1);
    checks++; if (digits !== 12'h071) begin errors++; $display("FAIL after_fresh got %h want 071", digits); end
  endtask

  task automatic test_ignored();
    int low_cnt;
    int busy_cnt;
    do_clear();
    low_cnt  = 0;
    busy_cnt = 0;
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.loadn === 1'b0) low_cnt++;
      if (bus.busy === 1'b1) busy_cnt++;
    end
    bus.start = 1'b0;
    checks++; if (low_cnt !== 0) begin errors++; $display("FAIL zero_start_loadn got %0d want 0", low_cnt); end
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL zero_start_busy got %0d want 0", busy_cnt); end
    press(4'd5);
    checks++; if (digits !== 12'h005) begin errors++; $display("FAIL key5 got %h want 005", digits); end
    press(4'd12);
    checks++; if (digits !== 12'h005) begin errors++; $display("FAIL bad_code got %h want 005", digits); end
    bus.running = 1'b1;
    press(4'd5);
    checks++; if (digits !== 12'h005) begin errors++; $display("FAIL run_key got %h want 005", digits); end
    low_cnt  = 0;
    busy_cnt = 0;
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.loadn === 1'b0) low_cnt++;
      if (bus.busy === 1'b1) busy_cnt++;
    end
    bus.start   = 1'b0;
    bus.running = 1'b0;
    checks++; if (low_cnt !== 0) begin errors++; $display("FAIL run_start_loadn got %0d want 0", low_cnt); end
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL run_start_busy got %0d want 0", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    // Key and start together; keep both asserted through NORM and LOAD to show they are ignored.
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd8;
    bus.start     = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL simul_busy got %b want 1", bus.busy); end
    checks++; if (digits !== 12'h005) begin errors++; $display("FAIL simul_drop got %h want 005", digits); end
    tick();
    checks++; if (bus.loadn !== 1'b0) begin errors++; $display("FAIL simul_load got %b want 0", bus.loadn); end
    checks++; if (digits !== 12'h005) begin errors++; $display("FAIL simul_data got %h want 005", digits); end
    bus.key_valid = 1'b0;
    bus.start     = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL no_queue_busy got %b want 0", bus.busy); end
    checks++; if (digits !== 12'h005) begin errors++; $display("FAIL no_queue_data got %h want 005", digits); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL no_queue_busy2 got %b want 0", bus.busy); end
  endtask

  task automatic test_clear_mid();
    int low_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++; if (bus.loadn !== 1'b0) begin errors++; $display("FAIL pre_clear_load got %b want 0", bus.loadn); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (bus.loadn !== 1'b1) begin errors++; $display("FAIL clear_load_loadn got %b want 1", bus.loadn); end
    checks++; if (digits !== 12'h000) begin errors++; $display("FAIL clear_load_data got %h want 000", digits); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clear_load_busy got %b want 0", bus.busy); end
    press(4'd4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL norm2_busy got %b want 1", bus.busy); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    low_cnt = 0;
    if (bus.loadn === 1'b0) low_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.loadn === 1'b0) low_cnt++;
    end
    checks++; if (low_cnt !== 0) begin errors++; $display("FAIL clear_norm_loadn got %0d want 0", low_cnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clear_norm_busy got %b want 0", bus.busy); end
    checks++; if (digits !== 12'h000) begin errors++; $display("FAIL clear_norm_data got %h want 000", digits); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clear = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.start     = 1'b0;
    bus.running   = 1'b0;
    test_reset();
    test_normal_load();
    test_normalize();
    test_overflow_fresh();
    test_ignored();
    test_back_to_back();
    test_clear_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port key_valid, input, 1 bit: one-cycle strobe marking a keypad digit present on key_code.
REQ-004 SHALL have port key_code, input, 4 bits: BCD digit 0-9.
REQ-005 SHALL have port start, input, 1 bit: request to load the entered time into the countdown chain.
REQ-006 SHALL have port running, input, 1 bit: high while the countdown chain is enabled.
REQ-007 SHALL have port min_digit, output, 4 bits: minutes digit; registered.
REQ-008 SHALL have port sec_tens, output, 4 bits: seconds tens digit; registered.
REQ-009 SHALL have port sec_ones, output, 4 bits: seconds ones digit; registered.
REQ-010 SHALL have port loadn, output, 1 bit: active-low synchronous load strobe to the counter chain's loadn inputs; registered.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, NORM and LOAD.
REQ-013 IDLE, key_valid=1, key_code<=9, running=0, start=0: SHALL shift left by one digit: min_digit<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_code; the old min_digit is discarded.
REQ-014 SHALL ignore key_valid with key_code 10-15: no digit change.
REQ-015 After a completed LOAD, the first accepted key SHALL first zero all three digits, then shift, giving 0:0k. A fresh flag set in LOAD and cleared by that key tracks this.
REQ-016 IDLE, start=1, running=0, any digit non-zero: SHALL go to NORM on the next edge.
REQ-017 start with all digits zero, or with running=1: SHALL be ignored and state SHALL stay IDLE.
REQ-018 key_valid and start high on the same IDLE edge: start SHALL win and the key SHALL be dropped.
REQ-019 NORM, one cycle, sec_tens>=6 and min_digit<=8: SHALL set sec_tens<=sec_tens-6 and min_digit<=min_digit+1; sec_ones is unchanged.
REQ-020 NORM, sec_tens>=6 and min_digit=9: SHALL saturate all digits to 9:5:9.
REQ-021 NORM, sec_tens<=5: SHALL leave all digits unchanged.
REQ-022 NORM SHALL always go to LOAD on the next edge.
REQ-023 LOAD, one cycle: loadn SHALL be 0; min_digit, sec_tens and sec_ones SHALL be stable and normalized; the state SHALL then go to IDLE.
REQ-024 loadn SHALL be 1 in every non-LOAD cycle.
REQ-025 Latency: start sampled at edge k gives NORM in cycle k..k+1 and loadn=0 in exactly cycle k+1..k+2.
REQ-026 SHALL ignore key_valid and start in NORM and LOAD, with no queuing.
REQ-027 Digits SHALL hold their values after LOAD and remain valid for display while running=1.
REQ-028 All digit outputs SHALL always be in range 0-9, with sec_tens<=5 after NORM.

Reset
REQ-029 clear=1 at an edge SHALL force state IDLE, all digits 0, loadn=1, busy=0 and fresh=0, overriding all other inputs.
REQ-030 clear in NORM or LOAD SHALL abort the sequence; loadn SHALL be 1 from that edge and no further load pulse SHALL occur.

Verification
REQ-031 Normal entry and load: clear; keys 1,3,0; start -> digits 1:3:0; busy for 2 cycles; loadn low exactly 1 cycle, one cycle after start is sampled, with data 1:3:0.
REQ-032 Normalization and saturation: keys 9,0 then start -> loaded 1:3:0. After that, keys 9,9,9 then start -> loaded 9:5:9.
REQ-033 Overflow and fresh entry: keys 1,2,3,4 -> 2:3:4. After a LOAD, key 7 -> 0:0:7.
REQ-034 Ignored inputs: all digits zero then start -> no loadn. Key 12 -> no change. running=1 with key 5 or start -> no change and no loadn.
REQ-035 Simultaneous events: key 8 together with start in IDLE -> key dropped, digits loaded unchanged.
REQ-036 Reset mid-operation: clear in the LOAD cycle -> loadn=1 at that edge, digits 0:0:0, state IDLE.
